ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch stage of the crane RISC-V core. Owns the program counter, drives the word address into the combinational instruction ROM, and captures each returned instruction with its PC into a 2-entry fetch queue. The queue feeds decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `imem_addr`  out  32: byte address to the instruction ROM; the ROM indexes by bits [31:2].
- `imem_instr`  in  32: ROM data, combinationally valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1: taken branch/jump; one-cycle pulse.
- `redirect_pc`  in  32: target PC, sampled when `redirect_valid`=1.
- `id_valid`  out  1: queue head holds a valid instruction.
- `id_ready`  in  1: decode accepts the head this cycle.
- `id_pc`  out  32: PC of the head entry.
- `id_instr`  out  32: instruction of the head entry.

## Operation
- State:
  - `fetch_pc` (32b).
  - Queue of 2 entries {pc, instr}, with a read pointer, a write pointer and `count` (0..2).
- `imem_addr` = `fetch_pc` at all times. This is a direct register output, not gated by stall.
- deq = `id_valid` & `id_ready`.
- push = !`redirect_valid` & (`count`<2 | deq).
  - On push: write {`fetch_pc`, `imem_instr`} at the write pointer.
  - Also on push: `fetch_pc` <= `fetch_pc` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
- No push: `fetch_pc` holds, so the ROM is re-read at the same address next cycle.
- Redirect has the highest priority. When `redirect_valid`=1:
  - `count` <= 0 and both pointers <= 0.
  - `fetch_pc` <= {`redirect_pc`[31:2], 2'b00}. Misaligned low bits are silently cleared.
  - No push and no effect from deq. A decode accept in the same cycle is still counted as taken by decode.
- Without redirect: `count` <= `count` + push − deq.
  - Full queue with simultaneous deq still pushes, so `count` stays 2.
- `id_valid` = (`count` != 0).
- `id_pc` and `id_instr` show the entry at the read pointer. When `count`=0 they show stale entry data; decode must ignore them.
- Handshake rules:
  - `id_pc` and `id_instr` are stable while `id_valid`=1 & `id_ready`=0.
  - Stability is not required across a redirect.

## Timing
- Reset (async assert, any cycle, including mid-operation):
  - `fetch_pc`=`RESET_PC`, `count`=0, pointers=0, all entries=0.
  - Hence `imem_addr`=`RESET_PC`, `id_valid`=0, `id_pc`=0, `id_instr`=0.
- First rising edge after `rst_n` deasserts pushes `RESET_PC`. `id_valid`=1 in the following cycle.
- Fetch-to-decode latency is 1 cycle: an instruction read in cycle N is at the head in cycle N+1 if the queue was empty.
- Throughput is 1 instruction/cycle with `id_ready` held high; `count` then stays at 1.
- Redirect asserted in cycle N:
  - Cycle N+1: `id_valid`=0 and `imem_addr`=target.
  - Cycle N+2: `id_valid`=1 with `id_pc`=target.
- Back-pressure: with `id_ready`=0 the queue fills in 2 cycles, then `fetch_pc` freezes. Fetch resumes in the same cycle `id_ready` rises (deq+push).

## Test plan
- Reset then free-run, ROM words 32'h00500513, 32'h00a00593, 32'h01400613, `id_ready`=1 → decode receives pc 0, 4, 8 with those instructions on 3 consecutive cycles. `id_valid` goes high exactly 1 cycle after reset release.
- Hold `id_ready`=0 for 5 cycles after reset, then raise it →
  - `count` saturates at 2 and `imem_addr` stays at 8.
  - After release, decode gets pc 0, 4, 8, 12 back-to-back with no gap, no duplicate and no drop.
- Redirect to 32'h0000_0040 while the queue holds pc 4 and 8, with `id_ready`=1 in the same cycle →
  - Next cycle: `id_valid`=0, `imem_addr`=0x40.
  - Following cycle: `id_pc`=0x40.
  - Entries 4 and 8 are never presented again.
- Redirect to 32'h0000_0022 → `imem_addr`=32'h0000_0020 next cycle.
- `RESET_PC`=32'hFFFF_FFF8, `id_ready`=1 → decode sees pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `rst_n`=0 asynchronously mid-stream with a full queue → `id_valid`=0 and `imem_addr`=`RESET_PC` immediately, before the next edge. After release, the stream restarts from `RESET_PC`.

Source files
------------

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, ROM address, 2-entry fetch queue to decode
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pc_mem_q [2];
  logic [31:0] pc_mem_d [2];
  logic [31:0] instr_mem_q [2];
  logic [31:0] instr_mem_d [2];
  logic        deq;
  logic        push;

  assign imem_addr = fetch_pc_q;
  assign id_valid  = (count_q != 2'd0);
  assign id_pc     = pc_mem_q[rd_ptr_q];
  assign id_instr  = instr_mem_q[rd_ptr_q];

  assign deq  = id_valid & id_ready;
  // A full queue can still accept the fetch when decode drains the head in the same cycle.
  assign push = !redirect_valid & ((count_q != 2'd2) | deq);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_instr;
        wr_ptr_d              = ~wr_ptr_q;
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (deq) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q     <= RESET_PC;
      count_q        <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      pc_mem_q[0]    <= 32'd0;
      pc_mem_q[1]    <= 32'd0;
      instr_mem_q[0] <= 32'd0;
      instr_mem_q[1] <= 32'd0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      pc_mem_q[0]    <= pc_mem_d[0];
      pc_mem_q[1]    <= pc_mem_d[1];
      instr_mem_q[0] <= instr_mem_d[0];
      instr_mem_q[1] <= instr_mem_d[1];
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed bench for ifetch
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] imem_addr, imem_instr, id_pc, id_instr;
  logic        id_valid;
  logic [31:0] w_imem_addr, w_imem_instr, w_id_pc, w_id_instr;
  logic        w_id_valid;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a[31:2])
      30'd0:   rom = 32'h00500513;
      30'd1:   rom = 32'h00a00593;
      30'd2:   rom = 32'h01400613;
      default: rom = {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign imem_instr   = rom(imem_addr);
  assign w_imem_instr = rom(w_imem_addr);

  ifetch u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(w_id_valid), .id_ready(id_ready), .id_pc(w_id_pc), .id_instr(w_id_instr)
  );

  // Leaves the bench at a falling edge with rst_n just released.
  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = rdy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    id_ready = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'd0); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    total++; if (id_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
    total++; if (id_instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
    total++; if (w_imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_wrap_addr got=%h exp=fffffff8", w_imem_addr); end
  endtask

  task automatic test_free_run;
    logic [31:0] ep [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] ei [3] = '{32'h00500513, 32'h00a00593, 32'h01400613};
    do_reset(1'b1);
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL free_valid_at_release got=%b exp=0", id_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL free_valid[%0d] got=%b exp=1", k, id_valid); end
      total++; if (id_pc !== ep[k]) begin bad++; $display("FAIL free_pc[%0d] got=%h exp=%h", k, id_pc, ep[k]); end
      total++; if (id_instr !== ei[k]) begin bad++; $display("FAIL free_instr[%0d] got=%h exp=%h", k, id_instr, ei[k]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea [5] = '{32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
    logic [31:0] ep [3] = '{32'h4, 32'h8, 32'hC};
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (imem_addr !== ea[k]) begin bad++; $display("FAIL bp_addr[%0d] got=%h exp=%h", k, imem_addr, ea[k]); end
      total++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin bad++; $display("FAIL bp_head[%0d] got=%h/%b exp=0/1", k, id_pc, id_valid); end
    end
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (id_valid !== 1'b1 || id_pc !== ep[k]) begin bad++; $display("FAIL bp_drain[%0d] got=%h/%b exp=%h/1", k, id_pc, id_valid, ep[k]); end
      if (k == 0) begin
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL bp_resume_addr got=%h exp=c", imem_addr); end
      end
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    id_ready = 1'b1;
    @(negedge clk);
    total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL rd_setup_head got=%h exp=4", id_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_n1 got=%b exp=0", id_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL rd_addr_n1 got=%h exp=40", imem_addr); end
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin bad++; $display("FAIL rd_head_n2 got=%h/%b exp=40/1", id_pc, id_valid); end
    total++; if (id_instr !== 32'h5A00_0043) begin bad++; $display("FAIL rd_instr_n2 got=%h exp=5a000043", id_instr); end
    @(negedge clk);
    total++; if (id_pc !== 32'h44) begin bad++; $display("FAIL rd_head_n3 got=%h exp=44", id_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    @(negedge clk);
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'h20 || id_valid !== 1'b0) begin bad++; $display("FAIL mis_addr got=%h/%b exp=20/0", imem_addr, id_valid); end
    @(negedge clk);
    total++; if (id_pc !== 32'h20) begin bad++; $display("FAIL mis_head got=%h exp=20", id_pc); end
  endtask

  task automatic test_wrap;
    logic [31:0] ep [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (w_id_valid !== 1'b1 || w_id_pc !== ep[k]) begin bad++; $display("FAIL wrap_pc[%0d] got=%h/%b exp=%h/1", k, w_id_pc, w_id_valid, ep[k]); end
    end
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL ar_full got=%h/%b exp=8/1", imem_addr, id_valid); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", id_valid); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h exp=0", imem_addr); end
    total++; if (w_imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL ar_wrap_addr got=%h exp=fffffff8", w_imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin bad++; $display("FAIL ar_restart0 got=%h/%b exp=0/1", id_pc, id_valid); end
    @(negedge clk);
    total++; if (id_pc !== 32'h4) begin bad++; $display("FAIL ar_restart1 got=%h exp=4", id_pc); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
